// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the CPU MEM stage (master) and the data-memory responder (slave).
// The master holds MEM_READ/MEM_WRITE/FUNC3/ADDRESS/WRITE_DATA stable while BUSY=1; READ_DATA is valid in the cycle BUSY drops.
interface data_mem_responder_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY;
  logic        MISALIGNED;

  modport master (
    output MEM_READ, MEM_WRITE, FUNC3, ADDRESS, WRITE_DATA,
    input  READ_DATA, BUSY, MISALIGNED
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, FUNC3, ADDRESS, WRITE_DATA,
    output READ_DATA, BUSY, MISALIGNED
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data-memory responder: IDLE -> ACCESS (LATENCY cycles) -> DONE, with lane select and extension.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into no-ops flagged on MISALIGNED.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [2:0]    cap_func3;
  logic          cap_store;
  logic          mis_q;
  logic [31:0]   read_data_q;

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [1:0]    lane;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          commit;
  logic          mis;
  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic          store_en;

  assign idx       = cap_addr[AW+1:2];
  assign word      = mem[idx];
  assign lane      = cap_addr[1:0];
  assign byte_sel  = word[{lane, 3'b000} +: 8];
  assign half_sel  = cap_addr[1] ? word[31:16] : word[15:0];
  assign commit    = (state == ACCESS) && (cnt == 4'd0);
  assign state_dbg = state;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    case (cap_func3)
      3'b001:  mis = cap_addr[0];
      3'b101:  mis = !cap_store && cap_addr[0];
      3'b010:  mis = |cap_addr[1:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    load_data = 32'd0;
    case (cap_func3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
    if (mis) load_data = 32'd0;
  end

  // Stores are a read-modify-write of the whole addressed word.
  always_comb begin
    merged   = word;
    store_en = 1'b0;
    case (cap_func3)
      3'b000: begin
        merged[{lane, 3'b000} +: 8] = cap_wdata[7:0];
        store_en = 1'b1;
      end
      3'b001: begin
        if (cap_addr[1]) merged[31:16] = cap_wdata[15:0];
        else             merged[15:0]  = cap_wdata[15:0];
        store_en = 1'b1;
      end
      3'b010: begin
        merged   = cap_wdata;
        store_en = 1'b1;
      end
      default: store_en = 1'b0;
    endcase
    if (mis) store_en = 1'b0;
  end

  always_comb begin
    bus.BUSY = 1'b0;
    if (!RST) begin
      case (state)
        IDLE:    bus.BUSY = bus.MEM_READ | bus.MEM_WRITE;
        ACCESS:  bus.BUSY = 1'b1;
        default: bus.BUSY = 1'b0;
      endcase
    end
  end

  assign bus.READ_DATA  = read_data_q;
  assign bus.MISALIGNED = mis_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      read_data_q <= 32'd0;
      mis_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MEM_READ || bus.MEM_WRITE) begin
            cap_addr  <= bus.ADDRESS;
            cap_func3 <= bus.FUNC3;
            cap_wdata <= bus.WRITE_DATA;
            cap_store <= bus.MEM_WRITE;
            cnt       <= 4'(LATENCY - 1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!cap_store) read_data_q <= load_data;
            mis_q <= mis;
            state <= DONE;
          end
        end
        DONE: begin
          // Inputs on this edge belong to the access just finished.
          mis_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && commit && cap_store && store_en) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-addressed reference model.
// Expected {MISALIGNED, READ_DATA} per access is queued by the driver and checked by a monitor at each DONE.
module tb_data_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  model_mem[DEPTH*4];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, returns {misaligned, read_data after access}.
  function automatic logic [32:0] model_access(input bit is_wr, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] wd);
    int          base;
    int          lane;
    int          h;
    bit          mis;
    logic [7:0]  b;
    logic [15:0] hw;
    logic [31:0] v;
    base = (int'(a / 4) % DEPTH) * 4;
    lane = int'(a % 4);
    h    = int'((a / 2) % 2) * 2;
    mis  = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if (f3 == 3'd2) mis = (lane != 0);
    else if (f3 == 3'd1 || (!is_wr && f3 == 3'd5)) mis = (a % 2) != 0;
`endif
    if (is_wr) begin
      if (!mis) begin
        case (f3)
          3'd0: model_mem[base+lane] = wd[7:0];
          3'd1: begin
            model_mem[base+h]   = wd[7:0];
            model_mem[base+h+1] = wd[15:8];
          end
          3'd2: for (int i = 0; i < 4; i++) model_mem[base+i] = wd[8*i +: 8];
          default: ;
        endcase
      end
    end else begin
      b  = model_mem[base+lane];
      hw = {model_mem[base+h+1], model_mem[base+h]};
      v  = 32'd0;
      case (f3)
        3'd0: v = b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
        3'd1: v = hw[15] ? (32'hFFFF0000 | 32'(hw)) : 32'(hw);
        3'd2: v = {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
        3'd4: v = 32'(b);
        3'd5: v = 32'(hw);
        default: v = 32'd0;
      endcase
      if (mis) v = 32'd0;
      last_rd = v;
    end
    return {mis, last_rd};
  endfunction

  // Drives one request starting right after a rising edge, holds it until DONE, then releases.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    int busy_cycles;
    int guard;
    exp_q.push_back(model_access(wr, f3, a, wd));
    @(posedge clk); #1;
    bus.MEM_READ   = rd;
    bus.MEM_WRITE  = wr;
    bus.FUNC3      = f3;
    bus.ADDRESS    = a;
    bus.WRITE_DATA = wd;
    #1;
    busy_cycles = bus.BUSY ? 1 : 0;
    guard = 0;
    while (guard < 50) begin
      @(posedge clk); #1;
      if (!bus.BUSY) break;
      busy_cycles++;
      guard++;
    end
    if (guard >= 50) check("busy_timeout", 32'd1, 32'd0);
    check("busy_cycles", 32'(busy_cycles), 32'(LATENCY + 1));
    bus.MEM_READ  = 1'b0;
    bus.MEM_WRITE = 1'b0;
  endtask

  // Monitor: DONE is the first non-reset cycle with BUSY low after BUSY was high.
  initial begin
    logic        prev_busy;
    logic [32:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !bus.BUSY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("read_data", bus.READ_DATA, e[31:0]);
            check("misaligned", 32'(bus.MISALIGNED), 32'(e[32]));
          end
        end
        prev_busy = bus.BUSY;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'd0;
    bus.MEM_READ   = 1'b1;
    bus.MEM_WRITE  = 1'b0;
    bus.FUNC3      = 3'd2;
    bus.ADDRESS    = 32'd0;
    bus.WRITE_DATA = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_read_data", bus.READ_DATA, 32'd0);
    check("reset_misaligned", 32'(bus.MISALIGNED), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    bus.MEM_READ = 1'b0;
    rst = 1'b0;

    // Word store/load and lane extraction.
    do_access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_access(1, 0, 3'd2, 32'h10, 32'h0);
    do_access(1, 0, 3'd0, 32'h13, 32'h0);
    do_access(1, 0, 3'd4, 32'h13, 32'h0);
    do_access(1, 0, 3'd1, 32'h12, 32'h0);
    do_access(1, 0, 3'd5, 32'h10, 32'h0);
    do_access(0, 1, 3'd1, 32'h12, 32'h00001234);
    do_access(1, 0, 3'd2, 32'h10, 32'h0);
    do_access(0, 1, 3'd0, 32'h11, 32'h00000055);
    do_access(1, 0, 3'd2, 32'h10, 32'h0);
    check("model_sb_word", {model_mem[19], model_mem[18], model_mem[17], model_mem[16]}, 32'h123455EF);

    // Reset during the second ACCESS cycle discards the store.
    @(posedge clk); #1;
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b1;
    bus.FUNC3      = 3'd2;
    bus.ADDRESS    = 32'h20;
    bus.WRITE_DATA = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    @(posedge clk); #1;
    check("rst_busy_hold", 32'(bus.BUSY), 32'd0);
    check("rst_read_data", bus.READ_DATA, 32'd0);
    bus.MEM_WRITE = 1'b0;
    last_rd = 32'd0;
    rst = 1'b0;
    do_access(1, 0, 3'd2, 32'h20, 32'h0);

    // Address wrap, undefined func3, both strobes high, misaligned accesses.
    do_access(0, 1, 3'd2, 32'h400, 32'h11111111);
    do_access(1, 0, 3'd2, 32'h0, 32'h0);
    do_access(1, 0, 3'd3, 32'h10, 32'h0);
    do_access(1, 1, 3'd2, 32'h24, 32'hA5A5A5A5);
    do_access(1, 0, 3'd2, 32'h24, 32'h0);
    do_access(0, 1, 3'd2, 32'h20, 32'h87654321);
    do_access(1, 0, 3'd2, 32'h22, 32'h0);
    do_access(0, 1, 3'd2, 32'h21, 32'hFFFFFFFF);
    do_access(1, 0, 3'd2, 32'h20, 32'h0);
    do_access(0, 1, 3'd1, 32'h21, 32'h0000BBBB);
    do_access(1, 0, 3'd5, 32'h23, 32'h0);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 2));
      f3   = 3'($urandom_range(0, 7));
      a    = (32'($urandom_range(0, 15)) << 10) | 32'($urandom_range(0, 63));
      do_access(kind != 1, kind != 0, f3, a, $urandom);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
